alu_exec_stage: RTL and testbench

Registered ALU execute stage directly downstream of the ALU decoder. It takes the decoder's operator, operand-select and immediate outputs together with register-file operands and the current PC. It selects operands, computes the 32-bit result and presents it on a valid/ready output. A two-entry buffer (output register plus skid register) absorbs one cycle of writeback backpressure without a combinational ready path.

---
 rtl/alu_exec_stage.sv | 161 ++++++++++++++++
 tb/tb_alu_exec_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// ALU execute stage: operand select, 32-bit ALU and a two-entry output buffer
// (output register + skid register) so the upstream ready never sees ready_i.
package alu_exec_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        OP_A_REG_A  = 2'd0,
        OP_A_CURRPC = 2'd1,
        OP_A_IMM    = 2'd2
    } op_a_sel_e;

    typedef enum logic [1:0] {
        OP_B_REG_B = 2'd0,
        OP_B_IMM   = 2'd1
    } op_b_sel_e;
endpackage

module alu_exec_stage
    import alu_exec_pkg::*;
#(
    parameter int TagW = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  alu_op_e         alu_operator_i,
    input  op_a_sel_e       alu_op_a_mux_sel_i,
    input  op_b_sel_e       alu_op_b_mux_sel_i,
    input  logic [31:0]     imm_i,
    input  logic [31:0]     rs1_rdata_i,
    input  logic [31:0]     rs2_rdata_i,
    input  logic [31:0]     pc_i,
    input  logic [TagW-1:0] tag_i,
    input  logic            we_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     result_o,
    output logic [TagW-1:0] tag_o,
    output logic            we_o
);

    localparam int DATA_W = 32;

    function automatic logic [DATA_W-1:0] alu_compute(
        input alu_op_e           op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] a_s;
        logic signed [DATA_W-1:0] b_s;
        logic        [4:0]        shamt;
        logic        [DATA_W-1:0] res;
        a_s   = $signed(a);
        b_s   = $signed(b);
        shamt = b[4:0];
        res   = '0;
        case (op)
            ALU_ADD:  res = a + b;
            ALU_SUB:  res = a - b;
            ALU_XOR:  res = a ^ b;
            ALU_OR:   res = a | b;
            ALU_AND:  res = a & b;
            ALU_SLT:  res = {{(DATA_W-1){1'b0}}, a_s < b_s};
            ALU_SLTU: res = {{(DATA_W-1){1'b0}}, a < b};
            ALU_SLL:  res = a << shamt;
            ALU_SRL:  res = a >> shamt;
            ALU_SRA:  res = $unsigned(a_s >>> shamt);
            default:  res = '0;
        endcase
        return res;
    endfunction

    logic [DATA_W-1:0] opa_p0;
    logic [DATA_W-1:0] opb_p0;
    logic [DATA_W-1:0] result_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] result_p1;
    logic [TagW-1:0]   tag_p1;
    logic              we_p1;

    logic              skid_vld_p1;
    logic [DATA_W-1:0] skid_result_p1;
    logic [TagW-1:0]   skid_tag_p1;
    logic              skid_we_p1;

    logic accept;
    logic pop;

    // Stage p0: operand selection and ALU, purely combinational
    always_comb begin
        opa_p0 = '0;
        case (alu_op_a_mux_sel_i)
            OP_A_REG_A:  opa_p0 = rs1_rdata_i;
            OP_A_CURRPC: opa_p0 = pc_i;
            default:     opa_p0 = '0;
        endcase
        opb_p0 = (alu_op_b_mux_sel_i == OP_B_REG_B) ? rs2_rdata_i : imm_i;
        result_p0 = alu_compute(alu_operator_i, opa_p0, opb_p0);
    end

    assign ready_o = !skid_vld_p1;
    assign accept  = valid_i & ready_o;
    assign pop     = vld_p1 & ready_i;

    // Stage p1: output register, with the skid entry always older than any new beat
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1         <= 1'b0;
            result_p1      <= '0;
            tag_p1         <= '0;
            we_p1          <= 1'b0;
            skid_vld_p1    <= 1'b0;
            skid_result_p1 <= '0;
            skid_tag_p1    <= '0;
            skid_we_p1     <= 1'b0;
        end else if (flush_i) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (skid_vld_p1) begin
            if (pop) begin
                vld_p1      <= 1'b1;
                result_p1   <= skid_result_p1;
                tag_p1      <= skid_tag_p1;
                we_p1       <= skid_we_p1;
                skid_vld_p1 <= 1'b0;
            end
        end else if (!vld_p1 || pop) begin
            vld_p1 <= accept;
            if (accept) begin
                result_p1 <= result_p0;
                tag_p1    <= tag_i;
                we_p1     <= we_i;
            end
        end else if (accept) begin
            skid_vld_p1    <= 1'b1;
            skid_result_p1 <= result_p0;
            skid_tag_p1    <= tag_i;
            skid_we_p1     <= we_i;
        end
    end

    assign valid_o  = vld_p1;
    assign result_o = result_p1;
    assign tag_o    = tag_p1;
    assign we_o     = we_p1;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: operator sweep, backpressure ordering,
// full throughput, flush and asynchronous reset.
module tb_alu_exec_stage;
    import alu_exec_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    alu_op_e     alu_operator_i;
    op_a_sel_e   alu_op_a_mux_sel_i;
    op_b_sel_e   alu_op_b_mux_sel_i;
    logic [31:0] imm_i;
    logic [31:0] rs1_rdata_i;
    logic [31:0] rs2_rdata_i;
    logic [31:0] pc_i;
    logic [4:0]  tag_i;
    logic        we_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [4:0]  tag_o;
    logic        we_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    alu_exec_stage #(.TagW(5)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .alu_operator_i     (alu_operator_i),
        .alu_op_a_mux_sel_i (alu_op_a_mux_sel_i),
        .alu_op_b_mux_sel_i (alu_op_b_mux_sel_i),
        .imm_i              (imm_i),
        .rs1_rdata_i        (rs1_rdata_i),
        .rs2_rdata_i        (rs2_rdata_i),
        .pc_i               (pc_i),
        .tag_i              (tag_i),
        .we_i               (we_i),
        .flush_i            (flush_i),
        .valid_o            (valid_o),
        .ready_i            (ready_i),
        .result_o           (result_o),
        .tag_o              (tag_o),
        .we_o               (we_o)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input alu_op_e op, input op_a_sel_e as, input op_b_sel_e bs,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                         input logic [31:0] pc, input logic [4:0] tg, input logic w);
        valid_i            = 1'b1;
        alu_operator_i     = op;
        alu_op_a_mux_sel_i = as;
        alu_op_b_mux_sel_i = bs;
        rs1_rdata_i        = r1;
        rs2_rdata_i        = r2;
        imm_i              = im;
        pc_i               = pc;
        tag_i              = tg;
        we_i               = w;
    endtask

    task automatic single(input string name, input alu_op_e op, input op_a_sel_e as,
                          input op_b_sel_e bs, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] im, input logic [31:0] pc, input logic [31:0] exp);
        drive(op, as, bs, r1, r2, im, pc, 5'd9, 1'b0);
        ready_i = 1'b1;
        step();
        check({name, "_valid"}, 32'(valid_o), 32'd1);
        check(name, result_o, exp);
        valid_i = 1'b0;
    endtask

    initial begin
        int next_tag;
        int exp_tag;
        logic acc;

        rst_ni  = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        flush_i = 1'b0;
        drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        valid_i = 1'b0;
        #1 rst_ni = 1'b0;
        #2;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_result", result_o, 32'h0);
        check("rst_tag", 32'(tag_o), 32'h0);
        check("rst_we", 32'(we_o), 32'h0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;

        // single beat
        drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd3, 1'b1);
        ready_i = 1'b1;
        step();
        valid_i = 1'b0;
        check("first_valid", 32'(valid_o), 32'd1);
        check("first_result", result_o, 32'h0000_000F);
        check("first_tag", 32'(tag_o), 32'd3);
        check("first_we", 32'(we_o), 32'd1);

        // operator sweep, a=0x8000_0000 b=0x21
        single("add",  ALU_ADD,  OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h8000_0021);
        single("sub",  ALU_SUB,  OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h7FFF_FFDF);
        single("xor",  ALU_XOR,  OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h8000_0021);
        single("or",   ALU_OR,   OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h8000_0021);
        single("and",  ALU_AND,  OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h0);
        single("slt",  ALU_SLT,  OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h1);
        single("sltu", ALU_SLTU, OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h0);
        single("sll",  ALU_SLL,  OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h0);
        single("srl",  ALU_SRL,  OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h4000_0000);
        single("sra",  ALU_SRA,  OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'hC000_0000);
        single("badop", alu_op_e'(4'hF), OP_A_REG_A, OP_B_REG_B, 32'h8000_0000, 32'h21, 32'h0, 32'h0, 32'h0);
        single("slt_pos", ALU_SLT, OP_A_REG_A, OP_B_REG_B, 32'h21, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
        single("sltu_pos", ALU_SLTU, OP_A_REG_A, OP_B_REG_B, 32'h21, 32'h8000_0000, 32'h0, 32'h0, 32'h1);
        single("pc_add", ALU_ADD, OP_A_CURRPC, OP_B_IMM, 32'hDEAD_BEEF, 32'h0, 32'h4, 32'h100, 32'h104);
        single("lui",  ALU_ADD,  OP_A_IMM,   OP_B_IMM,   32'hDEAD_BEEF, 32'h0, 32'h1234_5000, 32'h0, 32'h1234_5000);
        step();
        check("sweep_drain", 32'(valid_o), 32'd0);

        // backpressure: ready_i low for 3 cycles, tags 1..6 in order
        next_tag = 1;
        exp_tag  = 1;
        for (int cyc = 0; cyc < 40 && exp_tag <= 6; cyc++) begin
            ready_i = (cyc >= 3);
            if (next_tag <= 6)
                drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'(next_tag * 256), 32'h0,
                      32'(next_tag), 32'h0, 5'(next_tag), 1'b1);
            else
                valid_i = 1'b0;
            if (cyc == 1) check("bp_ready_one_buffered", 32'(ready_o), 32'd1);
            if (cyc == 2) check("bp_ready_full", 32'(ready_o), 32'd0);
            acc = valid_i && ready_o;
            if (valid_o && ready_i) begin
                check("bp_tag", 32'(tag_o), 32'(exp_tag));
                check("bp_result", result_o, 32'(exp_tag * 257));
                exp_tag++;
            end
            step();
            if (acc) next_tag++;
        end
        valid_i = 1'b0;
        check("bp_all_popped", 32'(exp_tag), 32'd7);
        check("bp_no_extra", 32'(valid_o), 32'd0);

        // back-to-back full throughput
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(ALU_ADD, OP_A_REG_A, OP_B_REG_B, 32'(i * 3), 32'd1000, 32'h0, 32'h0, 5'(i), 1'b1);
            check("b2b_ready", 32'(ready_o), 32'd1);
            step();
            check("b2b_valid", 32'(valid_o), 32'd1);
            check("b2b_result", result_o, 32'(i * 3 + 1000));
            check("b2b_tag", 32'(tag_o), 32'(i));
        end
        valid_i = 1'b0;
        step();
        check("b2b_drain", 32'(valid_o), 32'd0);

        // flush with both entries full and a beat waiting
        ready_i = 1'b0;
        drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'h1, 32'h0, 32'h0, 32'h0, 5'd10, 1'b1);
        step();
        drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'h2, 32'h0, 32'h0, 32'h0, 5'd11, 1'b1);
        step();
        check("fl_full_ready", 32'(ready_o), 32'd0);
        drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'h3, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("fl_valid", 32'(valid_o), 32'd0);
        check("fl_ready", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_quiet", 32'(valid_o), 32'd0);
        end

        // flush while accepting into an otherwise empty skid
        ready_i = 1'b0;
        drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'h5, 32'h0, 32'h0, 32'h0, 5'd13, 1'b1);
        step();
        drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'h6, 32'h0, 32'h0, 32'h0, 5'd14, 1'b1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        check("fl2_valid", 32'(valid_o), 32'd0);
        check("fl2_ready", 32'(ready_o), 32'd1);
        step();
        check("fl2_quiet", 32'(valid_o), 32'd0);

        // asynchronous reset with both entries full
        ready_i = 1'b0;
        drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'h7, 32'h0, 32'h0, 32'h0, 5'd15, 1'b1);
        step();
        drive(ALU_ADD, OP_A_REG_A, OP_B_IMM, 32'h8, 32'h0, 32'h0, 32'h0, 5'd16, 1'b1);
        step();
        valid_i = 1'b0;
        check("ar_full_ready", 32'(ready_o), 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        check("ar_valid", 32'(valid_o), 32'd0);
        check("ar_ready", 32'(ready_o), 32'd1);
        check("ar_result", result_o, 32'h0);
        check("ar_tag", 32'(tag_o), 32'h0);
        #2 rst_ni = 1'b1;
        ready_i = 1'b1;
        drive(ALU_SUB, OP_A_REG_A, OP_B_REG_B, 32'd50, 32'd8, 32'h0, 32'h0, 5'd21, 1'b1);
        step();
        valid_i = 1'b0;
        check("ar_fresh_valid", 32'(valid_o), 32'd1);
        check("ar_fresh_result", result_o, 32'd42);
        check("ar_fresh_tag", 32'(tag_o), 32'd21);
        step();
        check("ar_fresh_drain", 32'(valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
